// File: rtl/fsqrt_issue_if.sv
// Handshake and datapath bundle between the core, the fsqrt issue stage and the
// combinational fsqrt unit.
interface fsqrt_issue_if #(
    parameter int unsigned TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_x;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      sq_x;
    logic [31:0]      sq_y;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_y;
    logic [TAG_W-1:0] out_tag;
    logic             out_exc;

    // Core side plus the attached fsqrt datapath.
    modport master (
        output in_valid, in_x, in_tag, sq_y, out_ready,
        input  in_ready, sq_x, out_valid, out_y, out_tag, out_exc
    );

    // Issue stage side.
    modport slave (
        input  in_valid, in_x, in_tag, sq_y, out_ready,
        output in_ready, sq_x, out_valid, out_y, out_tag, out_exc
    );
endinterface

// File: rtl/fsqrt_issue.sv
// Request FIFO in front of a combinational fsqrt, with IEEE special-case
// resolution and a valid/ready output register.
module fsqrt_issue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 5
) (
    input logic          clk,
    input logic          rstn,
    fsqrt_issue_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic [31:0]      x;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_y_q, out_y_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_exc_q, out_exc_d;

    logic        full, empty, push, pop;
    entry_t      head;
    logic        head_s;
    logic [7:0]  head_e;
    logic [22:0] head_m;
    logic [31:0] res_y;
    logic        res_exc;

    assign full   = (count_q == CntW'(DEPTH));
    assign empty  = (count_q == '0);
    assign push   = bus.in_valid && !full;
    assign pop    = !empty && (!out_valid_q || bus.out_ready);
    assign head   = mem_q[rd_ptr_q];
    assign head_s = head.x[31];
    assign head_e = head.x[30:23];
    assign head_m = head.x[22:0];

    assign bus.in_ready  = !full;
    assign bus.sq_x      = empty ? 32'h0 : head.x;
    assign bus.out_valid = out_valid_q;
    assign bus.out_y     = out_y_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.out_exc   = out_exc_q;

    // Priority order matters: NaN before zero before negative before +inf.
    always_comb begin
        res_y   = bus.sq_y;
        res_exc = 1'b0;
        if (head_e == 8'hFF && head_m != '0) begin
            res_y   = 32'h7FC0_0000;
            res_exc = ~head_m[22];
        end else if (head_e == 8'h00) begin
            res_y = {head_s, 31'h0};
        end else if (head_s) begin
            res_y   = 32'h7FC0_0000;
            res_exc = 1'b1;
        end else if (head_e == 8'hFF) begin
            res_y = 32'h7F80_0000;
        end
    end

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_tag_d   = out_tag_q;
        out_exc_d   = out_exc_q;

        if (push) begin
            mem_d[wr_ptr_q] = '{x: bus.in_x, tag: bus.in_tag};
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end

        if (pop) begin
            rd_ptr_d    = rd_ptr_q + PtrW'(1);
            out_valid_d = 1'b1;
            out_y_d     = res_y;
            out_tag_d   = head.tag;
            out_exc_d   = res_exc;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Storage carries no reset; entries are only read once counted.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_y_q     <= 32'h0;
            out_tag_q   <= '0;
            out_exc_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_tag_q   <= out_tag_d;
            out_exc_q   <= out_exc_d;
        end
    end
endmodule
